// File: rtl/decode_issue_queue_pkg.sv
// Shared types and helpers for the decode issue queue.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package decode_issue_queue_pkg;

    localparam int DECODE_DATA_WIDTH = 206;

    // Field layout of one decoded-instruction bundle.
    localparam int FLD_VALID_BIT  = 0;
    localparam int FLD_PC_LSB     = 1;
    localparam int FLD_PC_MSB     = 32;
    localparam int FLD_INST_LSB   = 33;
    localparam int FLD_INST_MSB   = 64;
    localparam int FLD_ALUOP_LSB  = 65;
    localparam int FLD_ALUOP_MSB  = 72;
    localparam int FLD_ALUSEL_LSB = 73;
    localparam int FLD_ALUSEL_MSB = 75;
    localparam int FLD_IMM_LSB    = 76;
    localparam int FLD_IMM_MSB    = 107;
    localparam int FLD_CAUSE_LSB  = 199;
    localparam int FLD_CAUSE_MSB  = 205;

    // Lanes are capped at four, so helpers work on a 4-bit lane mask.
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    // True when v has the form 0..01..1 (including all-zero).
    function automatic logic is_prefix_mask(input logic [3:0] v);
        return (v & (v + 4'd1)) == 4'd0;
    endfunction

endpackage

// File: rtl/decode_issue_queue_if.sv
// Enqueue/dequeue bundle between decoders, the queue and dispatch.
// Latency: n/a (wires only).
// Backpressure: enq_ready gates all enqueue lanes; deq_ack is a prefix of deq_valid.
// master = decoder/dispatch side, slave = queue side.
interface decode_issue_queue_if #(
    parameter int DATA_W    = 206,
    parameter int ENQ_LANES = 2,
    parameter int DEQ_LANES = 2
);
    logic [ENQ_LANES-1:0]        enq_valid;
    logic [ENQ_LANES*DATA_W-1:0] enq_data;
    logic                        enq_ready;
    logic [DEQ_LANES-1:0]        deq_valid;
    logic [DEQ_LANES*DATA_W-1:0] deq_data;
    logic [DEQ_LANES-1:0]        deq_ack;

    modport master (
        output enq_valid, enq_data, deq_ack,
        input  enq_ready, deq_valid, deq_data
    );

    modport slave (
        input  enq_valid, enq_data, deq_ack,
        output enq_ready, deq_valid, deq_data
    );
endinterface

// File: rtl/decode_issue_queue_lane_compactor.sv
// Packs sparse valid lanes into consecutive low lanes, ascending lane order.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
// Ports: lane_valid/lane_data in, packed_valid (thermometer)/packed_data/n_valid out.
module lane_compactor
    import decode_issue_queue_pkg::*;
#(
    parameter int DATA_W = DECODE_DATA_WIDTH,
    parameter int LANES  = 2
) (
    input  logic [LANES-1:0]        lane_valid,
    input  logic [LANES*DATA_W-1:0] lane_data,
    output logic [LANES-1:0]        packed_valid,
    output logic [LANES*DATA_W-1:0] packed_data,
    output logic [2:0]              n_valid
);

    always_comb begin
        int k;
        k            = 0;
        packed_valid = '0;
        packed_data  = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_valid[i]) begin
                packed_valid[k]                  = 1'b1;
                packed_data[k*DATA_W +: DATA_W]  = lane_data[i*DATA_W +: DATA_W];
                k                                = k + 1;
            end
        end
        n_valid = popcount4(4'(lane_valid));
    end

endmodule

// File: rtl/decode_issue_queue.sv
// Multi-lane circular decode queue: packs sparse enqueue lanes, in-order partial dequeue.
// Latency: 1 cycle enqueue->dispatch; 0 cycles from empty with DECODE_QUEUE_BYPASS_EN.
// Backpressure: enq_ready drops (all lanes discarded) once free < ENQ_LANES; flush wins.
// Ports: clk, rst (async, active-low), flush, q_if (slave), count/full/empty/get_data_req.
// Optional macro DECODE_QUEUE_BYPASS_EN: show packed enqueue lanes on deq when empty.
module decode_issue_queue
    import decode_issue_queue_pkg::*;
#(
    parameter int DATA_W     = DECODE_DATA_WIDTH,
    parameter int DEPTH      = 16,
    parameter int ENQ_LANES  = 2,
    parameter int DEQ_LANES  = 2,
    parameter int REQ_MARGIN = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    decode_issue_queue_if.slave    q_if,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   get_data_req
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    // Pointers carry one extra wrap bit so tail-head spans 0..DEPTH.
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic [ENQ_LANES-1:0]        pk_valid;
    logic [ENQ_LANES*DATA_W-1:0] pk_data;
    logic [2:0]                  n_enq;
    logic [2:0]                  n_deq;
    logic [PTR_W-1:0]            free;
    logic                        enq_ok;
    logic                        enq_fire;
    logic [IDX_W-1:0]            widx;
    logic [IDX_W-1:0]            ridx;

    lane_compactor #(
        .DATA_W (DATA_W),
        .LANES  (ENQ_LANES)
    ) u_compactor (
        .lane_valid   (q_if.enq_valid),
        .lane_data    (q_if.enq_data),
        .packed_valid (pk_valid),
        .packed_data  (pk_data),
        .n_valid      (n_enq)
    );

    // Status comes from registered pointers only: no same-cycle dequeue credit.
    assign count          = tail_q - head_q;
    assign free           = PTR_W'(DEPTH) - count;
    assign enq_ok         = free >= PTR_W'(ENQ_LANES);
    assign q_if.enq_ready = enq_ok;
    assign full           = !enq_ok;
    assign empty          = (count == '0);
    assign get_data_req   = 32'(free) >= 32'(ENQ_LANES + REQ_MARGIN);
    assign enq_fire       = enq_ok && !flush;
    assign n_deq          = popcount4(4'(q_if.deq_ack));

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        mem_d  = mem_q;
        widx   = '0;
        if (flush) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            head_d = head_q + PTR_W'(n_deq);
            if (enq_fire) begin
                tail_d = tail_q + PTR_W'(n_enq);
                // Packed lane k lands at tail+k; index truncation wraps modulo DEPTH.
                for (int k = 0; k < ENQ_LANES; k++) begin
                    if (pk_valid[k]) begin
                        widx        = tail_q[IDX_W-1:0] + IDX_W'(k);
                        mem_d[widx] = pk_data[k*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    always_comb begin
        q_if.deq_valid = '0;
        q_if.deq_data  = '0;
        ridx           = '0;
        for (int j = 0; j < DEQ_LANES; j++) begin
            ridx                                = head_q[IDX_W-1:0] + IDX_W'(j);
            q_if.deq_valid[j]                   = count > PTR_W'(j);
            q_if.deq_data[j*DATA_W +: DATA_W]   = mem_q[ridx];
        end
`ifdef DECODE_QUEUE_BYPASS_EN
        // Empty queue: present the packed enqueue lanes directly. Acks on them
        // still advance head, so the entries written this cycle are consumed.
        if (empty && !flush) begin
            q_if.deq_valid = '0;
            for (int j = 0; j < DEQ_LANES && j < ENQ_LANES; j++) begin
                q_if.deq_valid[j]                 = pk_valid[j];
                q_if.deq_data[j*DATA_W +: DATA_W] = pk_data[j*DATA_W +: DATA_W];
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Entry contents need no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_decode_issue_queue.sv
// Self-checking bench for decode_issue_queue against a queue-based reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_decode_issue_queue;
    import decode_issue_queue_pkg::*;

    localparam int DATA_W = DECODE_DATA_WIDTH;
    localparam int DEPTH  = 16;
    localparam int EL     = 2;
    localparam int DL     = 2;
    localparam int RM     = 4;
    localparam int CW     = $clog2(DEPTH) + 1;
`ifdef DECODE_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst   = 1'b0;
    logic          flush = 1'b0;
    logic [CW-1:0] count;
    logic          full, empty, get_data_req;

    decode_issue_queue_if #(.DATA_W(DATA_W), .ENQ_LANES(EL), .DEQ_LANES(DL)) dif ();

    decode_issue_queue #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ENQ_LANES(EL), .DEQ_LANES(DL), .REQ_MARGIN(RM)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .q_if         (dif),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .get_data_req (get_data_req)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int wpos        = 0;                 // model write position since last reset/flush
    logic [DATA_W-1:0] mq[$];            // reference queue, front = head
    logic [DL-1:0]     exp_valid;
    logic [DATA_W-1:0] exp_lane [DL];

    function automatic logic [DATA_W-1:0] rand_bundle();
        logic [223:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[DATA_W-1:0];
    endfunction

    // Expected dispatch view from the model and the inputs currently driven.
    function automatic void compute_view();
        int k;
        k = 0;
        exp_valid = '0;
        for (int j = 0; j < DL; j++) exp_lane[j] = '0;
        if (BYP && mq.size() == 0 && !flush) begin
            for (int i = 0; i < EL; i++) begin
                if (dif.enq_valid[i]) begin
                    if (k < DL) begin
                        exp_valid[k] = 1'b1;
                        exp_lane[k]  = dif.enq_data[i*DATA_W +: DATA_W];
                    end
                    k++;
                end
            end
        end else begin
            for (int j = 0; j < DL; j++) begin
                if (j < mq.size()) begin
                    exp_valid[j] = 1'b1;
                    exp_lane[j]  = mq[j];
                end
            end
        end
    endfunction

    function automatic logic [CW+3:0] exp_status();
        int c;
        c = mq.size();
        return {CW'(c), c <= DEPTH - EL, c > DEPTH - EL, c == 0, (DEPTH - c) >= EL + RM};
    endfunction

    function automatic logic [DL-1:0] rand_ack();
        int n;
        compute_view();
        n = $countones(exp_valid);
        return DL'((1 << $urandom_range(n, 0)) - 1);
    endfunction

    task automatic drive(input logic [EL-1:0] ev, input logic [EL*DATA_W-1:0] ed,
                         input logic [DL-1:0] ak, input logic fl);
        dif.enq_valid = ev;
        dif.enq_data  = ed;
        dif.deq_ack   = ak;
        flush         = fl;
        #1;
    endtask

    // Clock edge plus model update; returns at negedge+1 with idle inputs.
    task automatic tick();
        logic [EL-1:0]        ev;
        logic [EL*DATA_W-1:0] ed;
        logic [DL-1:0]        ak;
        logic                 fl;
        logic [DATA_W-1:0]    dummy;
        bit                   ready;
        ev = dif.enq_valid;
        ed = dif.enq_data;
        ak = dif.deq_ack;
        fl = flush;
        compute_view();
        assert (is_prefix_mask(4'(ak)) && ((ak & ~exp_valid) == '0))
            else $error("illegal deq_ack stimulus %b", ak);
        @(posedge clk);
        if (fl) begin
            mq.delete();
            wpos = 0;
        end else begin
            ready = (mq.size() <= DEPTH - EL);
            if (ready) begin
                for (int i = 0; i < EL; i++)
                    if (ev[i]) mq.push_back(ed[i*DATA_W +: DATA_W]);
                wpos += $countones(ev);
            end
            repeat ($countones(ak)) if (mq.size() > 0) dummy = mq.pop_front();
        end
        @(negedge clk);
        dif.enq_valid = '0;
        dif.deq_ack   = '0;
        flush         = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        #3;
        vectors++; if (count !== '0) begin miscompares++; $display("FAIL reset_count got %0d exp 0", count); end
        vectors++; if (dif.enq_ready !== 1'b1) begin miscompares++; $display("FAIL reset_enq_ready got %b exp 1", dif.enq_ready); end
        vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full got %b exp 0", full); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got %b exp 1", empty); end
        vectors++; if (get_data_req !== 1'b1) begin miscompares++; $display("FAIL reset_req got %b exp 1", get_data_req); end
        vectors++; if (dif.deq_valid !== 2'b00) begin miscompares++; $display("FAIL reset_deq_valid got %b exp 00", dif.deq_valid); end
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic test_basic();
        logic [DATA_W-1:0] a, b;
        a = rand_bundle();
        b = rand_bundle();
        drive(2'b11, {b, a}, 2'b00, 1'b0); tick();
        vectors++; if (count !== CW'(2)) begin miscompares++; $display("FAIL basic_count got %0d exp 2", count); end
        vectors++; if (dif.deq_valid !== 2'b11) begin miscompares++; $display("FAIL basic_deq_valid got %b exp 11", dif.deq_valid); end
        vectors++; if (dif.deq_data[0 +: DATA_W] !== a) begin miscompares++; $display("FAIL basic_lane0 got %h exp %h", dif.deq_data[0 +: DATA_W], a); end
        vectors++; if (dif.deq_data[DATA_W +: DATA_W] !== b) begin miscompares++; $display("FAIL basic_lane1 got %h exp %h", dif.deq_data[DATA_W +: DATA_W], b); end
        drive(2'b00, '0, 2'b01, 1'b0); tick();
        vectors++; if (count !== CW'(1)) begin miscompares++; $display("FAIL basic_ack_count got %0d exp 1", count); end
        vectors++; if (dif.deq_data[0 +: DATA_W] !== b) begin miscompares++; $display("FAIL basic_ack_lane0 got %h exp %h", dif.deq_data[0 +: DATA_W], b); end
        vectors++; if (dif.deq_valid !== 2'b01) begin miscompares++; $display("FAIL basic_ack_valid got %b exp 01", dif.deq_valid); end
        drive(2'b00, '0, 2'b01, 1'b0); tick();
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL basic_drain_empty got %b exp 1", empty); end
    endtask

    task automatic test_sparse();
        logic [DATA_W-1:0] c;
        c = rand_bundle();
        drive(2'b10, {c, rand_bundle()}, 2'b00, 1'b0); tick();
        vectors++; if (count !== CW'(1)) begin miscompares++; $display("FAIL sparse_count got %0d exp 1", count); end
        vectors++; if (dif.deq_valid !== 2'b01) begin miscompares++; $display("FAIL sparse_valid got %b exp 01", dif.deq_valid); end
        vectors++; if (dif.deq_data[0 +: DATA_W] !== c) begin miscompares++; $display("FAIL sparse_lane0 got %h exp %h", dif.deq_data[0 +: DATA_W], c); end
        drive(2'b00, '0, 2'b01, 1'b0); tick();
    endtask

    task automatic test_fill();
        int c;
        for (int i = 0; i < 8; i++) begin
            c = (i == 0) ? 0 : 2 * i - 1;
            drive((i == 0) ? 2'b01 : 2'b11, {rand_bundle(), rand_bundle()}, 2'b00, 1'b0);
            vectors++; if (count !== CW'(c)) begin miscompares++; $display("FAIL fill_count step=%0d got %0d exp %0d", i, count, c); end
            vectors++; if (get_data_req !== ((DEPTH - c) >= EL + RM)) begin miscompares++; $display("FAIL fill_req count=%0d got %b exp %b", c, get_data_req, (DEPTH - c) >= EL + RM); end
            vectors++; if (dif.enq_ready !== 1'b1) begin miscompares++; $display("FAIL fill_ready count=%0d got %b exp 1", c, dif.enq_ready); end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            vectors++; if (count !== CW'(15)) begin miscompares++; $display("FAIL full_count try=%0d got %0d exp 15", i, count); end
            vectors++; if ({dif.enq_ready, full, get_data_req} !== 3'b010) begin miscompares++; $display("FAIL full_flags try=%0d got %b exp 010", i, {dif.enq_ready, full, get_data_req}); end
            drive((i == 0) ? 2'b11 : 2'b01, {rand_bundle(), rand_bundle()}, 2'b00, 1'b0); tick();
        end
        vectors++; if (count !== CW'(15)) begin miscompares++; $display("FAIL full_drop_count got %0d exp 15", count); end
        while (mq.size() > 0) begin
            drive(2'b00, '0, (mq.size() >= 2) ? 2'b11 : 2'b01, 1'b0);
            compute_view();
            for (int j = 0; j < DL; j++) begin
                if (exp_valid[j]) begin
                    vectors++;
                    if (dif.deq_data[j*DATA_W +: DATA_W] !== exp_lane[j]) begin miscompares++; $display("FAIL drain_lane%0d left=%0d got %h exp %h", j, mq.size(), dif.deq_data[j*DATA_W +: DATA_W], exp_lane[j]); end
                end
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        logic [DATA_W-1:0] d, e;
        while ((wpos % DEPTH) != DEPTH - 1) begin
            drive(2'b01, {rand_bundle(), rand_bundle()}, (mq.size() > 0) ? 2'b01 : 2'b00, 1'b0); tick();
        end
        if (mq.size() > 0) begin drive(2'b00, '0, 2'b01, 1'b0); tick(); end
        vectors++; if (count !== '0) begin miscompares++; $display("FAIL wrap_pre_count got %0d exp 0", count); end
        d = rand_bundle();
        e = rand_bundle();
        drive(2'b11, {e, d}, 2'b00, 1'b0); tick();
        vectors++; if (count !== CW'(2)) begin miscompares++; $display("FAIL wrap_count got %0d exp 2", count); end
        vectors++; if (dif.deq_data[0 +: DATA_W] !== d) begin miscompares++; $display("FAIL wrap_lane0 got %h exp %h", dif.deq_data[0 +: DATA_W], d); end
        vectors++; if (dif.deq_data[DATA_W +: DATA_W] !== e) begin miscompares++; $display("FAIL wrap_lane1 got %h exp %h", dif.deq_data[DATA_W +: DATA_W], e); end
        drive(2'b00, '0, 2'b11, 1'b0); tick();
        vectors++; if ({count, empty} !== {CW'(0), 1'b1}) begin miscompares++; $display("FAIL wrap_drain got count=%0d empty=%b exp 0/1", count, empty); end
    endtask

    task automatic test_flush();
        logic [DATA_W-1:0] f;
        drive(2'b01, {rand_bundle(), rand_bundle()}, 2'b00, 1'b0); tick();
        repeat (4) begin drive(2'b11, {rand_bundle(), rand_bundle()}, 2'b00, 1'b0); tick(); end
        vectors++; if (count !== CW'(9)) begin miscompares++; $display("FAIL flush_pre_count got %0d exp 9", count); end
        drive(2'b11, {rand_bundle(), rand_bundle()}, 2'b11, 1'b1);
        vectors++; if (dif.deq_valid !== 2'b11) begin miscompares++; $display("FAIL flush_cycle_valid got %b exp 11", dif.deq_valid); end
        tick();
        vectors++; if ({count, empty, dif.deq_valid} !== {CW'(0), 1'b1, 2'b00}) begin miscompares++; $display("FAIL flush_after got count=%0d empty=%b valid=%b exp 0/1/00", count, empty, dif.deq_valid); end
        f = rand_bundle();
        drive(2'b01, {rand_bundle(), f}, 2'b00, 1'b0); tick();
        vectors++; if (dif.deq_data[0 +: DATA_W] !== f) begin miscompares++; $display("FAIL flush_reuse_lane0 got %h exp %h", dif.deq_data[0 +: DATA_W], f); end
        drive(2'b00, '0, 2'b01, 1'b0); tick();
    endtask

    task automatic test_async_reset();
        drive(2'b01, {rand_bundle(), rand_bundle()}, 2'b00, 1'b0); tick();
        repeat (2) begin drive(2'b11, {rand_bundle(), rand_bundle()}, 2'b00, 1'b0); tick(); end
        vectors++; if (count !== CW'(5)) begin miscompares++; $display("FAIL areset_pre_count got %0d exp 5", count); end
        #1 rst = 1'b0;
        #1;
        vectors++; if ({count, empty, dif.deq_valid} !== {CW'(0), 1'b1, 2'b00}) begin miscompares++; $display("FAIL areset_clear got count=%0d empty=%b valid=%b exp 0/1/00", count, empty, dif.deq_valid); end
        #1 rst = 1'b1;
        mq.delete();
        wpos = 0;
        @(negedge clk);
        #1;
    endtask

    task automatic test_bypass();
        logic [DATA_W-1:0] a, b;
        a = rand_bundle();
        b = rand_bundle();
        drive(2'b11, {b, a}, BYP ? 2'b01 : 2'b00, 1'b0);
`ifdef DECODE_QUEUE_BYPASS_EN
        vectors++; if (dif.deq_valid !== 2'b11) begin miscompares++; $display("FAIL bypass_valid got %b exp 11", dif.deq_valid); end
        vectors++; if (dif.deq_data[0 +: DATA_W] !== a) begin miscompares++; $display("FAIL bypass_lane0 got %h exp %h", dif.deq_data[0 +: DATA_W], a); end
        tick();
        vectors++; if (count !== CW'(1)) begin miscompares++; $display("FAIL bypass_count got %0d exp 1", count); end
        vectors++; if (dif.deq_data[0 +: DATA_W] !== b) begin miscompares++; $display("FAIL bypass_next_lane0 got %h exp %h", dif.deq_data[0 +: DATA_W], b); end
`else
        vectors++; if (dif.deq_valid !== 2'b00) begin miscompares++; $display("FAIL nobypass_valid got %b exp 00", dif.deq_valid); end
        tick();
        vectors++; if (count !== CW'(2)) begin miscompares++; $display("FAIL nobypass_count got %0d exp 2", count); end
        vectors++; if (dif.deq_data[0 +: DATA_W] !== a) begin miscompares++; $display("FAIL nobypass_lane0 got %h exp %h", dif.deq_data[0 +: DATA_W], a); end
`endif
        while (mq.size() > 0) begin drive(2'b00, '0, 2'b01, 1'b0); tick(); end
    endtask

    task automatic test_random();
        logic [CW+3:0] got, exp;
        for (int cyc = 0; cyc < 600; cyc++) begin
            drive(2'($urandom_range(3, 0)), {rand_bundle(), rand_bundle()}, 2'b00, ($urandom_range(19, 0) == 0));
            dif.deq_ack = rand_ack();
            #1;
            compute_view();
            got = {count, dif.enq_ready, full, empty, get_data_req};
            exp = exp_status();
            vectors++; if (got !== exp) begin miscompares++; $display("FAIL rnd_status cyc=%0d got %b exp %b", cyc, got, exp); end
            vectors++; if (dif.deq_valid !== exp_valid) begin miscompares++; $display("FAIL rnd_valid cyc=%0d got %b exp %b", cyc, dif.deq_valid, exp_valid); end
            for (int j = 0; j < DL; j++) begin
                if (exp_valid[j]) begin
                    vectors++;
                    if (dif.deq_data[j*DATA_W +: DATA_W] !== exp_lane[j]) begin miscompares++; $display("FAIL rnd_lane%0d cyc=%0d got %h exp %h", j, cyc, dif.deq_data[j*DATA_W +: DATA_W], exp_lane[j]); end
                end
            end
            tick();
        end
    endtask

    initial begin
        dif.enq_valid = '0;
        dif.enq_data  = '0;
        dif.deq_ack   = '0;
        test_reset();
        test_basic();
        test_sparse();
        test_fill();
        test_wrap();
        test_flush();
        test_async_reset();
        test_bypass();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
